// File: rtl/axis_tag_framer_pkg.sv
// Shared types and defaults for the tag-aligned AXI4-Stream framer.
package axis_tag_framer_pkg;
   localparam int TAG_BIT_DEFAULT     = 208;
   localparam int TDATA_WIDTH_DEFAULT = 256;

   typedef enum logic {IDLE, FRAME} state_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered stream buffer; ready is derived from registered occupancy only.
module axis_skid_buffer #(
   parameter int DATA_WIDTH = 257
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [DATA_WIDTH-1:0] pop_data
);
   logic [1:0]            count;
   logic [DATA_WIDTH-1:0] head, tail;
   logic                  push, pop;

   assign push_ready = (count != 2'd2);
   assign pop_valid  = (count != 2'd0);
   assign pop_data   = head;
   assign push       = push_valid & push_ready;
   assign pop        = pop_valid & pop_ready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case ({push, pop})
            2'b11: begin
               // occupancy unchanged: the new word lands behind whatever remains
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/axis_tag_framer.sv
// Cuts a tagged sample stream into fixed-length frames that start on a tagged word.
module axis_tag_framer
   import axis_tag_framer_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = TDATA_WIDTH_DEFAULT,
   parameter int TAG_BIT          = TAG_BIT_DEFAULT,
   parameter int CNTR_WIDTH       = 16,
   parameter int CLEAR_TAG        = 0
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        cfg_enable,
   input  logic [CNTR_WIDTH-1:0]       cfg_length,
   output logic [31:0]                 sts_frames,
   output logic [31:0]                 sts_dropped,
   output logic [31:0]                 sts_missed,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast
);
   state_t                      state_q, state_d;
   logic [CNTR_WIDTH-1:0]       counter, len_reg;
   logic                        buf_ready, accept, tag;
   logic                        push, last, start, frame_done, drop, missed;
   logic [AXIS_TDATA_WIDTH-1:0] out_word;

   assign s_axis_tready = buf_ready;
   assign accept        = s_axis_tvalid & buf_ready;
   assign tag           = s_axis_tdata[TAG_BIT];

   always_comb begin
      out_word = s_axis_tdata;
      if (CLEAR_TAG != 0) out_word[TAG_BIT] = 1'b0;
   end

   always_comb begin
      state_d    = state_q;
      push       = 1'b0;
      last       = 1'b0;
      start      = 1'b0;
      frame_done = 1'b0;
      drop       = 1'b0;
      missed     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (tag && cfg_enable && (cfg_length != '0)) begin
                  push  = 1'b1;
                  start = 1'b1;
                  if (cfg_length == CNTR_WIDTH'(1)) begin
                     last       = 1'b1;
                     frame_done = 1'b1;
                  end else begin
                     state_d = FRAME;
                  end
               end else begin
                  drop = 1'b1;
               end
            end
         end
         FRAME: begin
            if (accept) begin
               push   = 1'b1;
               missed = tag;
               if (counter == len_reg - CNTR_WIDTH'(1)) begin
                  last       = 1'b1;
                  frame_done = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         counter     <= '0;
         len_reg     <= '0;
         sts_frames  <= 32'd0;
         sts_dropped <= 32'd0;
         sts_missed  <= 32'd0;
      end else begin
         state_q <= state_d;
         if (start) len_reg <= cfg_length;
         if (start) counter <= last ? '0 : CNTR_WIDTH'(1);
         else if (push) counter <= last ? '0 : counter + CNTR_WIDTH'(1);
         if (frame_done) sts_frames  <= sts_frames + 32'd1;
         if (drop)       sts_dropped <= sts_dropped + 32'd1;
         if (missed)     sts_missed  <= sts_missed + 32'd1;
      end
   end

   axis_skid_buffer #(
      .DATA_WIDTH(AXIS_TDATA_WIDTH + 1)
   ) u_skid (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .push_valid(push),
      .push_ready(buf_ready),
      .push_data ({last, out_word}),
      .pop_valid (m_axis_tvalid),
      .pop_ready (m_axis_tready),
      .pop_data  ({m_axis_tlast, m_axis_tdata})
   );
endmodule

// File: tb/tb_axis_tag_framer.sv
// Directed bench for axis_tag_framer with an output capture queue and stall checks.
module tb_axis_tag_framer;
   localparam int W   = 256;
   localparam int TAG = 208;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          cfg_enable = 1'b0;
   logic [15:0]   cfg_length = 16'd0;
   logic [31:0]   sts_frames, sts_dropped, sts_missed;
   logic          s_axis_tready;
   logic [W-1:0]  s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          m_axis_tready = 1'b1;
   logic [W-1:0]  m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;

   int checks = 0;
   int errors = 0;
   logic [W:0] out_q[$];
   logic [W:0] exp_q[$];
   int  push_cnt = 0, pop_cnt = 0;
   bit  occ_chk = 0, tog_mode = 0, prev_stall = 0;
   logic [W:0] prev_word = '0;
   bit  pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   int  ph = 0;

   axis_tag_framer dut (
      .aclk(aclk), .aresetn(aresetn), .cfg_enable(cfg_enable), .cfg_length(cfg_length),
      .sts_frames(sts_frames), .sts_dropped(sts_dropped), .sts_missed(sts_missed),
      .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input logic [263:0] got, input logic [263:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [W-1:0] wd(input int v, input bit t);
      logic [W-1:0] w;
      w = '0;
      w[31:0] = v;
      w[TAG] = t;
      return w;
   endfunction

   function automatic logic [W:0] ew(input int v, input bit t, input bit l);
      return {l, wd(v, t)};
   endfunction

   // Output capture, stall stability and occupancy model, all sampled mid-cycle.
   always @(negedge aclk) begin
      if (!aresetn) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", m_axis_tvalid, 1);
            chk("stall_word", {m_axis_tlast, m_axis_tdata}, prev_word);
         end
         if (occ_chk) chk("s_ready_occ", s_axis_tready, (push_cnt - pop_cnt) < 2);
         if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back({m_axis_tlast, m_axis_tdata});
            pop_cnt++;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_word  = {m_axis_tlast, m_axis_tdata};
      end
   end

   initial begin
      forever begin
         @(posedge aclk);
         #1;
         if (tog_mode) begin
            m_axis_tready = pat[ph];
            ph = (ph + 1) % 4;
         end
      end
   end

   task automatic send(input int v, input bit t);
      bit r, ok;
      ok = 0;
      s_axis_tdata  = wd(v, t);
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge aclk);
         r = s_axis_tready;
         @(posedge aclk);
         #1;
         if (r) ok = 1;
      end
      chk("send_accept", ok, 1);
      if (ok) push_cnt++;
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge aclk);
         if (!m_axis_tvalid) ok = 1;
      end
      chk("drain", ok, 1);
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      s_axis_tvalid = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      out_q.delete();
      exp_q.delete();
   endtask

   task automatic cmp_q(input string nm);
      chk({nm, "_count"}, out_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
         chk($sformatf("%s_w%0d", nm, i), out_q[i], exp_q[i]);
   endtask

   task automatic chk_sts(input string nm, input int f, input int d, input int m);
      chk({nm, "_frames"}, sts_frames, f);
      chk({nm, "_dropped"}, sts_dropped, d);
      chk({nm, "_missed"}, sts_missed, m);
   endtask

   initial begin
      // T1: length 4, tag on word 3
      do_reset();
      chk("rst_valid", m_axis_tvalid, 0);
      chk("rst_last", m_axis_tlast, 0);
      chk("rst_data", m_axis_tdata, 0);
      chk("rst_sready", s_axis_tready, 1);
      chk_sts("rst", 0, 0, 0);
      cfg_enable = 1; cfg_length = 4;
      for (int i = 0; i < 10; i++) begin
         send(i, i == 3);
         if (i == 3) chk("t1_drop_mid", sts_dropped, 3);
         if (i == 6) chk("t1_frames_mid", sts_frames, 1);
      end
      drain();
      for (int i = 3; i < 7; i++) exp_q.push_back(ew(i, i == 3, i == 6));
      cmp_q("t1");
      chk_sts("t1", 1, 6, 0);

      // T2: one-word frames
      do_reset();
      cfg_enable = 1; cfg_length = 1;
      for (int i = 0; i < 7; i++) send(i, i == 2 || i == 5);
      drain();
      exp_q.push_back(ew(2, 1, 1));
      exp_q.push_back(ew(5, 1, 1));
      cmp_q("t2");
      chk_sts("t2", 2, 5, 0);

      // T3: tag inside a frame does not restart it
      do_reset();
      cfg_enable = 1; cfg_length = 8;
      for (int i = 0; i < 10; i++) send(i, i == 0 || i == 3);
      drain();
      for (int i = 0; i < 8; i++) exp_q.push_back(ew(i, i == 0 || i == 3, i == 7));
      cmp_q("t3");
      chk_sts("t3", 1, 2, 1);

      // T4: backpressure pattern 1,0,0,1
      do_reset();
      cfg_enable = 1; cfg_length = 16;
      push_cnt = 0; pop_cnt = 0; ph = 0;
      tog_mode = 1; occ_chk = 1;
      for (int i = 0; i < 16; i++) send(i, i == 0);
      drain();
      occ_chk = 0; tog_mode = 0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 16; i++) exp_q.push_back(ew(i, i == 0, i == 15));
      cmp_q("t4");
      chk_sts("t4", 1, 0, 0);

      // T5: disabled tag dropped; config changes mid-frame ignored
      do_reset();
      cfg_enable = 0; cfg_length = 5;
      send(0, 1);
      chk("t5_drop_dis", sts_dropped, 1);
      cfg_enable = 1;
      send(1, 1);
      cfg_enable = 0; cfg_length = 2;
      for (int i = 2; i < 7; i++) send(i, 0);
      drain();
      for (int i = 1; i < 6; i++) exp_q.push_back(ew(i, i == 1, i == 5));
      cmp_q("t5");
      chk_sts("t5", 1, 2, 0);

      // T6: reset mid-frame, then a fresh frame
      do_reset();
      cfg_enable = 1; cfg_length = 6;
      send(0, 1); send(1, 0); send(2, 0);
      #2;
      aresetn = 1'b0;
      #1;
      chk("t6_rst_valid", m_axis_tvalid, 0);
      chk("t6_rst_last", m_axis_tlast, 0);
      chk_sts("t6_rst", 0, 0, 0);
      s_axis_tvalid = 1'b0;
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      out_q.delete();
      for (int i = 10; i < 17; i++) send(i, i == 10);
      drain();
      for (int i = 10; i < 16; i++) exp_q.push_back(ew(i, i == 10, i == 15));
      cmp_q("t6");
      chk_sts("t6", 1, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
